barrett_seq_ctrl: RTL



---
 rtl/barrett_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/barrett_seq_ctrl.sv
// Sequencer and final-correction stage around a digit-serial Barrett iteration core.
// Optional operand range rejection is enabled by defining BARRETT_SEQ_CTRL_RANGE_CHK_EN.
module barrett_seq_ctrl #(
    parameter int N        = 1024,
    parameter int M_DIG    = 4,
    parameter int CORR_MAX = 7,
    parameter int CW       = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [N-1:0]          X,
    input  logic [N-1:0]          Y,
    input  logic [N-1:0]          M,
    input  logic [M_DIG+4:0]      mu,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [N-1:0]          Z_res,
    output logic                  core_rst_n,
    output logic [N-1:0]          core_X,
    output logic [N-1:0]          core_M,
    output logic [M_DIG+4:0]      core_mu,
    output logic [M_DIG-1:0]      core_Yi,
    input  logic [N+M_DIG+1:0]    core_Z
);

    localparam int D  = N / M_DIG;
    localparam int RW = N + M_DIG + 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ITER,
        CAPT,
        CORR,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    ysr;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   r_q;
    logic [RW-1:0]   m_ext;
    logic            r_ge_m;
    logic            err_q;
    logic            range_bad;

`ifdef BARRETT_SEQ_CTRL_RANGE_CHK_EN
    assign range_bad = (X >= M) || (Y >= M);
`else
    assign range_bad = 1'b0;
`endif

    assign m_ext  = {{(M_DIG+2){1'b0}}, core_M};
    assign r_ge_m = (r_q >= m_ext);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cnt doubles as the digit counter in ITER and the subtraction count k in CORR
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_Yi    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = range_bad ? DONE : CLR;
                end
            end
            CLR: begin
                busy       = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                busy    = 1'b1;
                core_Yi = ysr[N-1 -: M_DIG];
                if (cnt == CW'(D-1)) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                busy       = 1'b1;
                state_next = CORR;
            end
            CORR: begin
                busy = 1'b1;
                if (!r_ge_m || (cnt == CW'(CORR_MAX))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // core_rst_n is registered so the core sees a glitch-free clear for exactly the CLR cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            core_X     <= '0;
            core_M     <= '0;
            core_mu    <= '0;
            ysr        <= '0;
            cnt        <= '0;
            r_q        <= '0;
            Z_res      <= '0;
            err_q      <= 1'b0;
            core_rst_n <= 1'b1;
        end else begin
            core_rst_n <= (state_next != CLR);
            case (state)
                IDLE: begin
                    if (start) begin
                        core_X  <= X;
                        core_M  <= M;
                        core_mu <= mu;
                        ysr     <= Y;
                        cnt     <= '0;
                        err_q   <= range_bad;
                        if (range_bad) begin
                            Z_res <= '0;
                        end
                    end
                end
                CLR: begin
                    cnt <= '0;
                end
                ITER: begin
                    ysr <= ysr << M_DIG;
                    cnt <= cnt + CW'(1);
                end
                CAPT: begin
                    r_q <= core_Z;
                    cnt <= '0;
                end
                CORR: begin
                    if (r_ge_m && (cnt != CW'(CORR_MAX))) begin
                        r_q <= r_q - m_ext;
                        cnt <= cnt + CW'(1);
                    end else begin
                        Z_res <= r_q[N-1:0];
                        err_q <= r_ge_m;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
